// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, default opcodes and the IR capture pattern.
// The state encoding follows the IEEE 1149.1 reference values, so State reads like a standard TAP.
package tap_pkg;

   typedef enum logic [3:0] {
      S_EXIT2_DR  = 4'h0,
      S_EXIT1_DR  = 4'h1,
      S_SHIFT_DR  = 4'h2,
      S_PAUSE_DR  = 4'h3,
      S_SEL_IR    = 4'h4,
      S_UPDATE_DR = 4'h5,
      S_CAP_DR    = 4'h6,
      S_SEL_DR    = 4'h7,
      S_EXIT2_IR  = 4'h8,
      S_EXIT1_IR  = 4'h9,
      S_SHIFT_IR  = 4'hA,
      S_PAUSE_IR  = 4'hB,
      S_RTI       = 4'hC,
      S_UPDATE_IR = 4'hD,
      S_CAP_IR    = 4'hE,
      S_TLR       = 4'hF
   } tap_state_e;

   localparam logic [1:0] OPC_EXTEST = 2'b00;
   localparam logic [1:0] OPC_SAMPLE = 2'b01;
   localparam logic [1:0] OPC_BYPASS = 2'b11;

   // Captured into the IR shift register: LSB = 1, every other bit 0.
   localparam int unsigned IR_CAPTURE = 1;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine: state register and TMS-driven next-state logic only.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       TCLK,
   input  logic       RstBar,
   input  logic       TMS,
   output logic [3:0] State
);

   tap_state_e state_q;

   always_ff @(posedge TCLK or negedge RstBar) begin
      if (!RstBar) begin
         state_q <= S_TLR;
      end else begin
         case (state_q)
            S_TLR:       state_q <= TMS ? S_TLR       : S_RTI;
            S_RTI:       state_q <= TMS ? S_SEL_DR    : S_RTI;
            S_SEL_DR:    state_q <= TMS ? S_SEL_IR    : S_CAP_DR;
            S_CAP_DR:    state_q <= TMS ? S_EXIT1_DR  : S_SHIFT_DR;
            S_SHIFT_DR:  state_q <= TMS ? S_EXIT1_DR  : S_SHIFT_DR;
            S_EXIT1_DR:  state_q <= TMS ? S_UPDATE_DR : S_PAUSE_DR;
            S_PAUSE_DR:  state_q <= TMS ? S_EXIT2_DR  : S_PAUSE_DR;
            S_EXIT2_DR:  state_q <= TMS ? S_UPDATE_DR : S_SHIFT_DR;
            S_UPDATE_DR: state_q <= TMS ? S_SEL_DR    : S_RTI;
            S_SEL_IR:    state_q <= TMS ? S_TLR       : S_CAP_IR;
            S_CAP_IR:    state_q <= TMS ? S_EXIT1_IR  : S_SHIFT_IR;
            S_SHIFT_IR:  state_q <= TMS ? S_EXIT1_IR  : S_SHIFT_IR;
            S_EXIT1_IR:  state_q <= TMS ? S_UPDATE_IR : S_PAUSE_IR;
            S_PAUSE_IR:  state_q <= TMS ? S_EXIT2_IR  : S_PAUSE_IR;
            S_EXIT2_IR:  state_q <= TMS ? S_UPDATE_IR : S_SHIFT_IR;
            S_UPDATE_IR: state_q <= TMS ? S_SEL_DR    : S_RTI;
            default:     state_q <= S_TLR;
         endcase
      end
   end

   assign State = state_q;

endmodule

// File: rtl/tap_controller.sv
// Boundary-scan TAP controller: instruction register, bypass register, BSR control
// decode and the negedge-timed TDO path around the tap_fsm state machine.
module tap_controller
   import tap_pkg::*;
#(
   parameter int                  IR_WIDTH  = 2,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OPC_EXTEST),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OPC_SAMPLE),
   parameter logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(OPC_BYPASS)
) (
   input  logic       TCLK,
   input  logic       RstBar,
   input  logic       TMS,
   input  logic       TDI,
   input  logic       BSR_SO,
   output logic       BSR_SI,
   output logic       TDO,
   output logic       TDO_En,
   output logic       ShiftBR,
   output logic       ClockBR,
   output logic       UpdateBR,
   output logic       ModeControl,
   output logic [3:0] State
);

   localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(IR_CAPTURE);

   logic [3:0]          state;
   tap_state_e          st;
   logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic                bypass_q, bypass_d;
   logic                tdo_q, tdo_d;
   logic                tdo_en_q, tdo_en_d;
   logic                bsel;

   tap_fsm u_fsm (
      .TCLK   (TCLK),
      .RstBar (RstBar),
      .TMS    (TMS),
      .State  (state)
   );

   assign st    = tap_state_e'(state);
   assign State = state;

   // Undefined opcodes fall through to the bypass path because bsel stays low.
   assign bsel = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);

   assign BSR_SI      = TDI;
   assign ClockBR     = !(bsel && ((st == S_CAP_DR) || (st == S_SHIFT_DR)));
   assign ShiftBR     = (st == S_SHIFT_DR);
   assign UpdateBR    = bsel && (st == S_UPDATE_DR);
   assign ModeControl = (ir_q == OP_EXTEST);
   assign TDO         = tdo_q;
   assign TDO_En      = tdo_en_q;

   always_comb begin
      ir_shift_d = ir_shift_q;
      bypass_d   = bypass_q;
      case (st)
         S_CAP_IR:   ir_shift_d = IR_CAP;
         S_SHIFT_IR: ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
         S_CAP_DR:   bypass_d   = 1'b0;
         S_SHIFT_DR: if (!bsel) bypass_d = TDI;
         default:    ;
      endcase
   end

   always_ff @(posedge TCLK or negedge RstBar) begin
      if (!RstBar) begin
         ir_shift_q <= '0;
         bypass_q   <= 1'b0;
      end else begin
         ir_shift_q <= ir_shift_d;
         bypass_q   <= bypass_d;
      end
   end

   always_comb begin
      ir_d = ir_q;
      if (st == S_TLR) begin
         ir_d = OP_BYPASS;
      end else if (st == S_UPDATE_IR) begin
         ir_d = ir_shift_q;
      end
   end

   always_comb begin
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (st == S_SHIFT_IR) begin
         tdo_d    = ir_shift_q[0];
         tdo_en_d = 1'b1;
      end else if (st == S_SHIFT_DR) begin
         tdo_d    = bsel ? BSR_SO : bypass_q;
         tdo_en_d = 1'b1;
      end
   end

   // IR and TDO move on the falling edge so they are stable across the next rising edge.
   always_ff @(negedge TCLK or negedge RstBar) begin
      if (!RstBar) begin
         ir_q     <= OP_BYPASS;
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

endmodule

// File: tb/tb_tap_controller.sv
// Randomised bench for tap_controller with an 8-cell BSR model, a queue-based
// reference of the serial path and a TDO scoreboard.
module tb_tap_controller;
   import tap_pkg::*;

   logic       TCLK = 1'b0;
   logic       RstBar;
   logic       TMS;
   logic       TDI;
   logic       BSR_SO;
   logic       BSR_SI;
   logic       TDO;
   logic       TDO_En;
   logic       ShiftBR;
   logic       ClockBR;
   logic       UpdateBR;
   logic       ModeControl;
   logic [3:0] State;

   always #5 TCLK = ~TCLK;

   tap_controller dut (
      .TCLK        (TCLK),
      .RstBar      (RstBar),
      .TMS         (TMS),
      .TDI         (TDI),
      .BSR_SO      (BSR_SO),
      .BSR_SI      (BSR_SI),
      .TDO         (TDO),
      .TDO_En      (TDO_En),
      .ShiftBR     (ShiftBR),
      .ClockBR     (ClockBR),
      .UpdateBR    (UpdateBR),
      .ModeControl (ModeControl),
      .State       (State)
   );

   // 8-cell boundary-scan register: cell 0 takes BSR_SI, cell 7 drives BSR_SO.
   logic [7:0] bsr_cap = 8'h00;
   logic [7:0] bsr_upd = 8'h00;
   logic [7:0] bsr_din = 8'h00;

   always @(posedge TCLK) if (ClockBR === 1'b0) bsr_cap <= ShiftBR ? {bsr_cap[6:0], BSR_SI} : bsr_din;
   always @(negedge TCLK) if (UpdateBR === 1'b1) bsr_upd <= bsr_cap;
   assign BSR_SO = bsr_cap[7];

   // Reference model
   tap_state_e nxt [16][2];
   tap_state_e m_state;
   logic [1:0] m_ir;
   logic [7:0] m_dout;
   bit         path_q[$];
   bit         exp_tdo_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic bit is_bsel(input logic [1:0] ir);
      return (ir == OPC_EXTEST) || (ir == OPC_SAMPLE);
   endfunction

   task automatic set_t(input tap_state_e s, input tap_state_e on0, input tap_state_e on1);
      nxt[int'(s)][0] = on0;
      nxt[int'(s)][1] = on1;
   endtask

   task automatic init_table();
      set_t(S_TLR,       S_RTI,       S_TLR);
      set_t(S_RTI,       S_RTI,       S_SEL_DR);
      set_t(S_SEL_DR,    S_CAP_DR,    S_SEL_IR);
      set_t(S_CAP_DR,    S_SHIFT_DR,  S_EXIT1_DR);
      set_t(S_SHIFT_DR,  S_SHIFT_DR,  S_EXIT1_DR);
      set_t(S_EXIT1_DR,  S_PAUSE_DR,  S_UPDATE_DR);
      set_t(S_PAUSE_DR,  S_PAUSE_DR,  S_EXIT2_DR);
      set_t(S_EXIT2_DR,  S_SHIFT_DR,  S_UPDATE_DR);
      set_t(S_UPDATE_DR, S_RTI,       S_SEL_DR);
      set_t(S_SEL_IR,    S_CAP_IR,    S_TLR);
      set_t(S_CAP_IR,    S_SHIFT_IR,  S_EXIT1_IR);
      set_t(S_SHIFT_IR,  S_SHIFT_IR,  S_EXIT1_IR);
      set_t(S_EXIT1_IR,  S_PAUSE_IR,  S_UPDATE_IR);
      set_t(S_PAUSE_IR,  S_PAUSE_IR,  S_EXIT2_IR);
      set_t(S_EXIT2_IR,  S_SHIFT_IR,  S_UPDATE_IR);
      set_t(S_UPDATE_IR, S_RTI,       S_SEL_DR);
   endtask

   task automatic check_outputs();
      logic       bs;
      logic       sh;
      logic [8:0] exp_v;
      logic [8:0] act_v;
      bs    = is_bsel(m_ir);
      sh    = (m_state == S_SHIFT_IR) || (m_state == S_SHIFT_DR);
      exp_v = {m_state,
               !(bs && ((m_state == S_CAP_DR) || (m_state == S_SHIFT_DR))),
               (m_state == S_SHIFT_DR),
               bs && (m_state == S_UPDATE_DR),
               (m_ir == OPC_EXTEST),
               sh};
      act_v = {State, ClockBR, ShiftBR, UpdateBR, ModeControl, TDO_En};
      check("ctrl{state,clk,shift,upd,mode,en}", 32'(act_v), 32'(exp_v));
      if (!sh) check("tdo_idle", 32'(TDO), 32'd0);
      check("bsr_dout", 32'(bsr_upd), 32'(m_dout));
   endtask

   // One TCLK: drive inputs, advance the model at posedge, apply negedge effects, then check.
   task automatic step(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCLK);
      case (m_state)
         S_CAP_IR: begin
            path_q.delete();
            path_q.push_back(1'b1);
            path_q.push_back(1'b0);
         end
         S_CAP_DR: begin
            path_q.delete();
            if (is_bsel(m_ir)) for (int i = 7; i >= 0; i--) path_q.push_back(bsr_din[i]);
            else path_q.push_back(1'b0);
         end
         S_SHIFT_IR, S_SHIFT_DR: begin
            void'(path_q.pop_front());
            path_q.push_back(tdi);
         end
         default: ;
      endcase
      m_state = nxt[int'(m_state)][int'(tms)];
      @(negedge TCLK);
      if ((m_state == S_SHIFT_IR) || (m_state == S_SHIFT_DR)) exp_tdo_q.push_back(path_q[0]);
      if (m_state == S_TLR) m_ir = OPC_BYPASS;
      else if (m_state == S_UPDATE_IR) m_ir = {path_q[1], path_q[0]};
      else if ((m_state == S_UPDATE_DR) && is_bsel(m_ir) && (path_q.size() == 8))
         for (int i = 0; i < 8; i++) m_dout[i] = path_q[7 - i];
      #1;
      check_outputs();
   endtask

   // Full IR or DR scan from RTI back to RTI; data[0] is shifted first.
   task automatic scan(input bit is_ir, input int n, input logic [31:0] data,
                       input int pause_after, input int pause_len);
      bit last;
      step(1'b1, 1'($urandom));
      if (is_ir) step(1'b1, 1'($urandom));
      step(1'b0, 1'($urandom));
      step(1'b0, 1'($urandom));
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         step(last || (i == pause_after), data[i]);
         if (!last && (i == pause_after)) begin
            step(1'b0, 1'($urandom));
            repeat (pause_len - 1) step(1'b0, 1'($urandom));
            step(1'b1, 1'($urandom));
            step(1'b0, 1'($urandom));
         end
      end
      step(1'b1, 1'($urandom));
      step(1'b0, 1'($urandom));
   endtask

   // Scoreboard monitor: every TDO_En cycle consumes one expected bit.
   initial begin
      bit e;
      forever begin
         @(negedge TCLK);
         #1;
         if ((RstBar === 1'b1) && (TDO_En === 1'b1)) begin
            if (exp_tdo_q.size() == 0) begin
               check("tdo_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_tdo_q.pop_front();
               check("tdo", 32'(TDO), 32'(e));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int kind;
      init_table();
      RstBar  = 1'b0;
      TMS     = 1'b1;
      TDI     = 1'b0;
      m_state = S_TLR;
      m_ir    = OPC_BYPASS;
      m_dout  = 8'h00;
      repeat (2) @(negedge TCLK);
      #1;
      check_outputs();
      RstBar = 1'b1;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);

      // EXTEST load, then a DR scan of 8'hA5 into the BSR
      scan(1'b1, 2, 32'h0, -1, 1);
      check("mode_after_extest", 32'(ModeControl), 32'd1);
      bsr_din = 8'($urandom);
      scan(1'b0, 8, 32'hA5, -1, 1);
      check("bsr_dout_a5", 32'(bsr_upd), 32'hA5);

      // Five TMS=1 clocks reach TLR and restore BYPASS
      repeat (5) step(1'b1, 1'($urandom));
      check("tlr_after_5", 32'(State), 32'(S_TLR));
      check("mode_after_tlr", 32'(ModeControl), 32'd0);
      step(1'b0, 1'b0);

      // BYPASS: 1,0,1,1,0,0,1,0 delayed by one clock
      scan(1'b1, 2, 32'h3, -1, 1);
      scan(1'b0, 8, 32'h4D, -1, 1);

      // SAMPLE with a 3-cycle pause mid-shift
      scan(1'b1, 2, 32'h1, -1, 1);
      bsr_din = 8'($urandom);
      scan(1'b0, 8, $urandom, 3, 3);

      // Asynchronous reset in the middle of SHIFT_DR under EXTEST
      scan(1'b1, 2, 32'h0, -1, 1);
      bsr_din = 8'($urandom);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'($urandom));
      #2;
      RstBar = 1'b0;
      #1;
      m_state = S_TLR;
      m_ir    = OPC_BYPASS;
      path_q.delete();
      check("reset_mid_scan", 32'({State, ClockBR, ShiftBR, UpdateBR, ModeControl, TDO_En, TDO}),
            32'({4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
      @(negedge TCLK);
      #1;
      check_outputs();
      RstBar = 1'b1;
      step(1'b0, 1'b0);

      for (int it = 0; it < 30; it++) begin
         kind = int'($urandom_range(0, 2));
         case (kind)
            0: scan(1'b1, int'($urandom_range(2, 5)), $urandom,
                    int'($urandom_range(0, 8)), int'($urandom_range(1, 3)));
            1: begin
               bsr_din = 8'($urandom);
               scan(1'b0, int'($urandom_range(1, 20)), $urandom,
                    int'($urandom_range(0, 25)), int'($urandom_range(1, 4)));
            end
            default: begin
               repeat ($urandom_range(3, 12)) step(1'($urandom), 1'($urandom));
               repeat (5) step(1'b1, 1'($urandom));
               check("tlr_from_any", 32'(State), 32'(S_TLR));
               step(1'b0, 1'b0);
            end
         endcase
      end

      @(negedge TCLK);
      #2;
      check("tdo_queue_drained", 32'(exp_tdo_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
IEEE 1149.1-style TAP controller that drives the boundary-scan register chain's control inputs ShiftBR, ClockBR, UpdateBR and ModeControl from the TMS/TDI serial interface.
Contains:
- the 16-state TAP FSM
- an instruction register with EXTEST, SAMPLE/PRELOAD and BYPASS decode
- a 1-bit bypass register
- the TDO output mux

Sits between the chip's test pins and the BSR chain. The chain's serial output returns as BSR_SO.

Parameters:
IR_WIDTH, 2, instruction register length (minimum 2).
OP_EXTEST, 2'b00, opcode selecting the BSR with ModeControl=1.
OP_SAMPLE, 2'b01, opcode selecting the BSR with ModeControl=0.
OP_BYPASS, 2'b11, opcode selecting the bypass register. Every undefined opcode also decodes as BYPASS.

Ports:
TCLK  in  1  test clock.
RstBar  in  1  asynchronous, active-low reset.
TMS  in  1  test mode select, sampled on posedge TCLK.
TDI  in  1  serial data in, sampled on posedge TCLK.
BSR_SO  in  1  serial out of the last BSR cell.
BSR_SI  out  1  serial in to the first BSR cell; equals TDI combinationally.
TDO  out  1  serial data out, changes on negedge TCLK.
TDO_En  out  1  TDO output enable.
ShiftBR  out  1  BSR shift select (1 = take Sin).
ClockBR  out  1  BSR capture/shift enable, active-low (0 = cells load).
UpdateBR  out  1  BSR update enable (cells update on negedge TCLK).
ModeControl  out  1  1 = BSR outputs drive pins.
State  out  4  current TAP state, for debug.

Behaviour:
- Reset (RstBar=0, async):
  - state = TEST_LOGIC_RESET
  - IR = OP_BYPASS, IR shift register = 0, bypass = 0
  - TDO = 0, TDO_En = 0
  - ShiftBR = 0, ClockBR = 1, UpdateBR = 0, ModeControl = 0
- FSM: 16 standard states, next state on posedge TCLK from TMS. Transitions as (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SHIFT_DR / EXIT1_DR
  - SHIFT_DR: SHIFT_DR / EXIT1_DR
  - EXIT1_DR: PAUSE_DR / UPDATE_DR
  - PAUSE_DR: PAUSE_DR / EXIT2_DR
  - EXIT2_DR: SHIFT_DR / UPDATE_DR
  - UPDATE_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR column mirrors the DR column.
- TMS=1 for 5 consecutive TCLKs reaches TLR from any state.
- In TLR, IR is forced to OP_BYPASS synchronously.
- Encoding lives in the package; State outputs the raw encoding.
- BSR selected (bsel) = IR is OP_EXTEST or OP_SAMPLE.
- Control outputs are combinational decode of the registered state and IR, so they are glitch-free relative to posedge:
  - ClockBR = 0 iff bsel and state in {CAP_DR, SHIFT_DR}; else 1.
  - ShiftBR = 1 iff state = SHIFT_DR.
  - UpdateBR = 1 iff bsel and state = UPDATE_DR. The cell update flop latches on the negedge within UPDATE_DR.
  - ModeControl = 1 iff IR = OP_EXTEST. It changes only when IR updates (negedge in UPDATE_IR) or on reset.
- IR shift register:
  - CAP_IR (posedge): loads the fixed pattern with LSB = 1, all other bits 0.
  - SHIFT_IR: shifts right, TDI into the MSB.
  - UPDATE_IR: copied to IR on negedge TCLK.
- Bypass register:
  - CAP_DR: loads 0.
  - SHIFT_DR with not bsel: loads TDI.
  - Otherwise holds.
- TDO, registered on negedge TCLK:
  - SHIFT_IR: ir_shift[0].
  - SHIFT_DR and bsel: BSR_SO.
  - SHIFT_DR and not bsel: bypass.
  - All other states: 0.
  - TDO_En is set on the same negedge: 1 iff state in {SHIFT_IR, SHIFT_DR}.
- Latency:
  - BYPASS adds exactly 1 TCLK from TDI to TDO.
  - An N-cell BSR adds N TCLKs.
- Pause states hold all shift contents. ClockBR = 1 there.
- Reset mid-scan: immediate TLR. A partial IR shift is discarded and IR becomes BYPASS. BSR update flops do not update.

Decomposition:
- Package tap_pkg holds:
  - state localparams (4-bit)
  - opcode constants
  - IR_CAPTURE pattern
- Sub-module tap_fsm holds the state register and next-state logic only, with ports TCLK, RstBar, TMS, State.
- tap_controller instantiates tap_fsm and owns IR, bypass, decode and the TDO logic.

Test Plan:
- Assert RstBar=0 mid-SHIFT_DR, then release -> State=TLR, ClockBR=1, ShiftBR=0, UpdateBR=0, ModeControl=0, TDO_En=0.
- From RTI after loading EXTEST, drive TMS=1 for 5 TCLKs -> State=TLR, IR=2'b11, ModeControl=0.
- From TLR:
  - Drive TMS sequence 0,1,1,0,0 then shift IR bits 0,0, with TMS=1 on the last bit, then TMS 1,0 -> ModeControl rises at the UPDATE_IR negedge.
  - TDO during the shift shows 1,0 (the capture pattern).
- With EXTEST and an 8-cell BSR, perform a DR scan of 8'hA5 -> ClockBR=0 in CAP_DR and all 8 SHIFT_DR cycles.
  - UpdateBR=1 only in UPDATE_DR.
  - BSR Dout=8'hA5 after the negedge.
  - TDO returns the previously captured Din.
- With BYPASS, shift 8 bits 1,0,1,1,0,0,1,0 -> TDO shows 0 then the same bits delayed by 1 TCLK.
  - ClockBR stays 1 and UpdateBR stays 0 throughout.
- Run SHIFT_DR -> PAUSE_DR for 3 cycles -> EXIT2 -> SHIFT_DR with SAMPLE selected.
  - ClockBR=1 during pause.
  - Shifted data continues with no loss or duplication.
